uart_tx: RTL and testbench

UART transmitter, the transmit-side companion to the team's UART receiver. It accepts a parallel byte over a valid/ready handshake and serialises it as start, data MSB-first, optional parity, then stop bit(s). The bit order and parity match what our receiver expects. One clock domain; bit timing comes from an internal baud divider, so no separate baud clock input is needed.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and the baud-period helper
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Clocks per bit, truncated; callers reject results below 2.
    function automatic int calcBitCyc(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..BIT_CYC-1 while enabled and flags the last clock
// of each bit. Dropping en restarts the count so the next bit is full length.
module uart_baud_gen #(
    parameter int BIT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_end
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] r_cnt;

    generate
        if (BIT_CYC < 2) begin : g_badBitCyc
            $error("uart_baud_gen: BIT_CYC must be at least 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, serialised as start, data MSB-first,
// optional parity and one or two stop bits. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int PARITY     = 1,
    parameter int PARITY_ODD = 0,
    parameter int DI_WIDTH   = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DI_WIDTH-1:0] din,
    input  logic                din_vld,
    output logic                din_rdy,
    output logic                tx,
    output logic                busy
);

    localparam int   BIT_CYC = calcBitCyc(CLK_FREQ, BAUD_RATE);
    localparam int   IW      = $clog2(DI_WIDTH);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    generate
        if (BIT_CYC < 2) begin : g_badBitCyc
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (DI_WIDTH < 5 || DI_WIDTH > 8) begin : g_badWidth
            $error("uart_tx: DI_WIDTH must be 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_e         r_state, w_nextState;
    logic [DI_WIDTH-1:0] r_shreg, w_nextShreg;
    logic [IW-1:0]       r_bitIdx, w_nextBitIdx;
    logic                r_stopCnt, w_nextStopCnt;
    logic                r_parity, w_nextParity;
    logic                r_tx, w_nextTx;
    logic                r_rdy;
    logic                r_busy;
    logic                w_accept;
    logic                w_bitEnd;
    logic [DI_WIDTH-1:0] w_shifted;

    assign w_accept  = din_vld && r_rdy;
    assign w_shifted = {r_shreg[DI_WIDTH-2:0], 1'b0};

    uart_baud_gen #(
        .BIT_CYC(BIT_CYC)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (r_state != ST_IDLE),
        .bit_end(w_bitEnd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bitIdx  <= '0;
            r_stopCnt <= 1'b0;
            r_parity  <= 1'b0;
            r_tx      <= LINE_IDLE;
            r_rdy     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_shreg   <= w_nextShreg;
            r_bitIdx  <= w_nextBitIdx;
            r_stopCnt <= w_nextStopCnt;
            r_parity  <= w_nextParity;
            r_tx      <= w_nextTx;
            r_rdy     <= (w_nextState == ST_IDLE);
            r_busy    <= (w_nextState != ST_IDLE);
        end
    end

    // tx is loaded with the level of the state being entered, so the line is registered.
    always_comb begin
        w_nextState   = r_state;
        w_nextShreg   = r_shreg;
        w_nextBitIdx  = r_bitIdx;
        w_nextStopCnt = r_stopCnt;
        w_nextParity  = r_parity;
        w_nextTx      = r_tx;
        case (r_state)
            ST_IDLE: begin
                w_nextTx = LINE_IDLE;
                if (w_accept) begin
                    w_nextState  = ST_START;
                    w_nextShreg  = din;
                    w_nextParity = (^din) ^ PAR_ODD;
                    w_nextTx     = START_BIT;
                end
            end
            ST_START: begin
                if (w_bitEnd) begin
                    w_nextState  = ST_DATA;
                    w_nextBitIdx = IW'(DI_WIDTH - 1);
                    w_nextTx     = r_shreg[DI_WIDTH-1];
                end
            end
            ST_DATA: begin
                if (w_bitEnd) begin
                    w_nextShreg = w_shifted;
                    if (r_bitIdx == '0) begin
                        if (PAR_EN) begin
                            w_nextState = ST_PARITY;
                            w_nextTx    = r_parity;
                        end else begin
                            w_nextState   = ST_STOP;
                            w_nextStopCnt = 1'b0;
                            w_nextTx      = LINE_IDLE;
                        end
                    end else begin
                        w_nextBitIdx = r_bitIdx - 1'b1;
                        w_nextTx     = w_shifted[DI_WIDTH-1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bitEnd) begin
                    w_nextState   = ST_STOP;
                    w_nextStopCnt = 1'b0;
                    w_nextTx      = LINE_IDLE;
                end
            end
            ST_STOP: begin
                w_nextTx = LINE_IDLE;
                if (w_bitEnd) begin
                    if (r_stopCnt == 1'(STOP_BITS - 1)) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextStopCnt = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextTx    = LINE_IDLE;
            end
        endcase
    end

    assign din_rdy = r_rdy;
    assign tx      = r_tx;
    assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_CYC=16: one instance with even parity and one
// stop bit, one with odd parity and two stop bits; frames are sampled at bit centres.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din0, din1;
    logic       vld0, vld1;
    logic       rdy0, rdy1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int checkCount;
    int errorCount;

    uart_tx #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .PARITY(1),
        .PARITY_ODD(0), .DI_WIDTH(8), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_vld(vld0),
        .din_rdy(rdy0), .tx(tx0), .busy(busy0)
    );

    uart_tx #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .PARITY(1),
        .PARITY_ODD(1), .DI_WIDTH(8), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_vld(vld1),
        .din_rdy(rdy1), .tx(tx1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic getTx(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic getRdy(input int sel);
        return (sel != 0) ? rdy1 : rdy0;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents a word at a falling edge and returns just after the accepting edge.
    task automatic applyStimulus(input int sel, input logic [7:0] word, input logic hold);
        @(negedge clk);
        if (sel != 0) begin
            din1 = word;
            vld1 = 1'b1;
        end else begin
            din0 = word;
            vld0 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            vld0 = 1'b0;
            vld1 = 1'b0;
        end
    endtask

    // Called right after the accepting edge; samples every bit centre and measures
    // the clocks until din_rdy returns. Optionally pokes a request into dut0 mid-frame.
    task automatic sampleFrame(input int sel, input logic [11:0] expBits, input int nBits,
                               input int expLen, input int injectAt, input string tag);
        int  c;
        int  k;
        logic done;
        done = 1'b0;
        c = 0;
        @(negedge clk);
        checkOutput({tag, "_start"}, 32'(getTx(sel)), 32'd0);
        checkOutput({tag, "_busy"}, 32'(getBusy(sel)), 32'd1);
        while (!done && c < 400) begin
            if (c == injectAt) begin
                din0 = 8'hFF;
                vld0 = 1'b1;
            end
            if (c == injectAt + 1) vld0 = 1'b0;
            @(negedge clk);
            c++;
            if (c >= 8 && ((c - 8) % 16) == 0 && ((c - 8) / 16) < nBits) begin
                k = (c - 8) / 16;
                checkOutput($sformatf("%s_bit%0d", tag, k), 32'(getTx(sel)),
                            32'(expBits[nBits-1-k]));
            end
            if (getRdy(sel)) done = 1'b1;
        end
        checkOutput({tag, "_len"}, 32'(c), 32'(expLen));
        checkOutput({tag, "_idleBusy"}, 32'(getBusy(sel)), 32'd0);
    endtask

    task automatic checkQuiet(input int cycles, input string tag);
        logic disturbed;
        disturbed = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0 ||
                tx1 !== 1'b1 || rdy1 !== 1'b1 || busy1 !== 1'b0) disturbed = 1'b1;
        end
        checkOutput(tag, 32'(disturbed), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst  = 1'b0;
        din0 = 8'h00;
        din1 = 8'h00;
        vld0 = 1'b0;
        vld1 = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("rstTx", 32'(tx0), 32'd1);
        checkOutput("rstRdy", 32'(rdy0), 32'd1);
        checkOutput("rstBusy", 32'(busy0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("relTx", 32'(tx0), 32'd1);
        checkOutput("relRdy", 32'(rdy0), 32'd1);
        checkOutput("relBusy", 32'(busy0), 32'd0);
        checkQuiet(100, "resetIdle");

        $display("[TB] single frame 0xA5 even parity");
        applyStimulus(0, 8'hA5, 1'b0);
        sampleFrame(0, 12'b0_01010010101, 11, 176, -10, "a5");

        $display("[TB] odd parity, two stop bits, 0x01");
        applyStimulus(1, 8'h01, 1'b0);
        sampleFrame(1, 12'b000000001011, 12, 192, -10, "odd2stop");

        $display("[TB] back-to-back 0x55 then 0x0F");
        applyStimulus(0, 8'h55, 1'b1);
        din0 = 8'h0F;
        sampleFrame(0, 12'b0_00101010101, 11, 176, -10, "b2bA");
        checkOutput("b2bGap", 32'(tx0), 32'd1);
        @(posedge clk);
        #1;
        vld0 = 1'b0;
        sampleFrame(0, 12'b0_00000111101, 11, 176, -10, "b2bB");
        checkQuiet(40, "b2bNoThird");

        $display("[TB] request ignored mid-frame");
        applyStimulus(0, 8'hA5, 1'b0);
        sampleFrame(0, 12'b0_01010010101, 11, 176, 50, "ignore");
        checkQuiet(100, "ignoreNoExtra");

        $display("[TB] reset during data");
        applyStimulus(0, 8'h00, 1'b0);
        repeat (70) @(negedge clk);
        checkOutput("midDataLow", 32'(tx0), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncTx", 32'(tx0), 32'd1);
        checkOutput("asyncRdy", 32'(rdy0), 32'd1);
        checkOutput("asyncBusy", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checkQuiet(20, "postReset");
        applyStimulus(0, 8'h3C, 1'b0);
        sampleFrame(0, 12'b0_00011110001, 11, 176, -10, "x3c");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
